// File: rtl/dsp_mac_pkg.sv
// dsp_mac_pkg
//   Shared constants, the channel-select width helper and the control word
//   that travels alongside the product through the multiplier pipeline.
package dsp_mac_pkg;

   localparam int MAX_OP_W  = 27;   // widest supported operand
   localparam int MAX_RES_W = 64;   // widest supported accumulator
   localparam int MAX_CH    = 8;    // most accumulators per instance
   localparam int MAX_CH_W  = 3;    // channel field width able to hold 0..MAX_CH-1

   // Channel select width: at least one bit even for a single channel.
   function automatic int ch_w(input int channels);
      if (channels <= 32'sd2) begin
         return 32'sd1;
      end else begin
         return $clog2(channels);
      end
   endfunction

   // Per-sample control carried through the product pipeline.
   // chan is always MAX_CH_W wide so the type is independent of CHANNELS.
   typedef struct packed {
      logic                valid;
      logic [MAX_CH_W-1:0] chan;
      logic                acc_clear;
   } mac_ctl_t;

endpackage

// File: rtl/dsp_mult_pipe.sv
// dsp_mult_pipe
//   Pipelined multiplier with STAGES register stages. The product is sign- or
//   zero-extended to RESULT_WIDTH before the first register, and the sample's
//   control word moves in lock-step with it. sclr clears every stage so no
//   in-flight sample survives a reset.
// Ports
//   clk      in   clock, all logic on posedge
//   i_sclr   in   synchronous active-high reset
//   i_ax     in   operand A (AX_WIDTH)
//   i_ay     in   operand B (AY_WIDTH)
//   i_ctl    in   control word of the sample presented this cycle
//   o_prod   out  extended product, STAGES cycles later
//   o_ctl    out  control word matching o_prod
module dsp_mult_pipe
   import dsp_mac_pkg::*;
#(
   parameter string FAMILY       = "Agilex",
   parameter int    AX_WIDTH     = 27,
   parameter int    AY_WIDTH     = 27,
   parameter int    RESULT_WIDTH = 64,
   parameter int    SIGNED       = 1,
   parameter int    STAGES       = 2
) (
   input  logic                    clk,
   input  logic                    i_sclr,
   input  logic [AX_WIDTH-1:0]     i_ax,
   input  logic [AY_WIDTH-1:0]     i_ay,
   input  mac_ctl_t                i_ctl,
   output logic [RESULT_WIDTH-1:0] o_prod,
   output mac_ctl_t                o_ctl
);

   localparam int PW = AX_WIDTH + AY_WIDTH;

   // The multiplier mapping depends on the target family; an empty name is a setup error.
   if (FAMILY == "") begin : g_bad_family
      $error("dsp_mult_pipe: FAMILY must name a target family");
   end

   logic [PW-1:0]           w_ax_ext;
   logic [PW-1:0]           w_ay_ext;
   logic [PW-1:0]           w_prod_raw;
   logic [RESULT_WIDTH-1:0] w_prod_ext;

   mac_ctl_t                r_ctl  [STAGES];
   logic [RESULT_WIDTH-1:0] r_prod [STAGES];

   // Operand extension and full-width product; the low PW bits are exact for both signedness modes.
   always_comb begin
      w_ax_ext   = '0;
      w_ay_ext   = '0;
      w_prod_ext = '0;
      if (SIGNED != 0) begin
         w_ax_ext   = PW'($signed(i_ax));
         w_ay_ext   = PW'($signed(i_ay));
         w_prod_raw = w_ax_ext * w_ay_ext;
         w_prod_ext = RESULT_WIDTH'($signed(w_prod_raw));
      end else begin
         w_ax_ext   = PW'(i_ax);
         w_ay_ext   = PW'(i_ay);
         w_prod_raw = w_ax_ext * w_ay_ext;
         w_prod_ext = RESULT_WIDTH'(w_prod_raw);
      end
   end

   // Product/control shift pipeline, cleared as a whole on sclr.
   always_ff @(posedge clk) begin
      if (i_sclr) begin
         for (int i = 0; i < STAGES; i++) begin
            r_ctl[i]  <= '0;
            r_prod[i] <= '0;
         end
      end else begin
         r_ctl[0]  <= i_ctl;
         r_prod[0] <= w_prod_ext;
         for (int i = 1; i < STAGES; i++) begin
            r_ctl[i]  <= r_ctl[i-1];
            r_prod[i] <= r_prod[i-1];
         end
      end
   end

   assign o_prod = r_prod[STAGES-1];
   assign o_ctl  = r_ctl[STAGES-1];

endmodule

// File: rtl/dsp_mac_nch.sv
// dsp_mac_nch
//   Pipelined multiply-accumulate with CHANNELS interleaved accumulators.
//   LATENCY-1 product stages feed a single accumulate/output stage that reads
//   its own accumulator registers, so back-to-back samples on one channel
//   chain without stalls.
// Ports
//   clk        in   clock, all logic on posedge
//   sclr       in   synchronous active-high reset, discards in-flight samples
//   valid_in   in   sample qualifier
//   ax, ay     in   operands
//   chan       in   accumulator select; values >= CHANNELS drop the sample
//   acc_clear  in   load the product instead of adding it
//   valid_out  out  result qualifier
//   chan_out   out  channel of the presented result
//   result     out  updated accumulator value
//   overflow   out  this result wrapped
module dsp_mac_nch
   import dsp_mac_pkg::*;
#(
   parameter string FAMILY       = "Agilex",
   parameter int    AX_WIDTH     = 27,
   parameter int    AY_WIDTH     = 27,
   parameter int    RESULT_WIDTH = 64,
   parameter int    LATENCY      = 3,
   parameter int    CHANNELS     = 4,
   parameter int    SIGNED       = 1
) (
   input  logic                          clk,
   input  logic                          sclr,
   input  logic                          valid_in,
   input  logic [AX_WIDTH-1:0]           ax,
   input  logic [AY_WIDTH-1:0]           ay,
   input  logic [ch_w(CHANNELS)-1:0]     chan,
   input  logic                          acc_clear,
   output logic                          valid_out,
   output logic [ch_w(CHANNELS)-1:0]     chan_out,
   output logic [RESULT_WIDTH-1:0]       result,
   output logic                          overflow
);

   localparam int                CH_W       = ch_w(CHANNELS);
   localparam int                RW         = RESULT_WIDTH;
   localparam logic [CH_W:0]     CH_LIMIT   = (CH_W+1)'(CHANNELS);
   localparam logic [MAX_CH_W:0] CH_LIMIT_W = (MAX_CH_W+1)'(CHANNELS);

   if (AX_WIDTH < 2 || AX_WIDTH > MAX_OP_W || AY_WIDTH < 2 || AY_WIDTH > MAX_OP_W ||
       RESULT_WIDTH < AX_WIDTH + AY_WIDTH || RESULT_WIDTH > MAX_RES_W ||
       LATENCY < 2 || CHANNELS < 1 || CHANNELS > MAX_CH) begin : g_bad_params
      $error("dsp_mac_nch: parameter out of supported range");
   end

   mac_ctl_t          w_ctl_in;
   mac_ctl_t          w_ctl;
   logic [RW-1:0]     w_prod;
   logic              w_take;
   logic [CH_W-1:0]   w_sel;
   logic [RW-1:0]     w_old;
   logic [RW:0]       w_sum;
   logic [RW-1:0]     w_new;
   logic              w_ov;

   logic [RW-1:0]     r_acc [CHANNELS];
   logic              r_valid;
   logic [CH_W-1:0]   r_chan;
   logic [RW-1:0]     r_result;
   logic              r_ov;

   // Qualify the incoming sample; illegal channels never enter the pipeline as valid.
   always_comb begin
      w_ctl_in = '0;
      if (valid_in && ({1'b0, chan} < CH_LIMIT)) begin
         w_ctl_in.valid     = 1'b1;
         w_ctl_in.chan      = MAX_CH_W'(chan);
         w_ctl_in.acc_clear = acc_clear;
      end else begin
         w_ctl_in = '0;
      end
   end

   dsp_mult_pipe #(
      .FAMILY       (FAMILY),
      .AX_WIDTH     (AX_WIDTH),
      .AY_WIDTH     (AY_WIDTH),
      .RESULT_WIDTH (RESULT_WIDTH),
      .SIGNED       (SIGNED),
      .STAGES       (LATENCY - 1)
   ) u_mult (
      .clk    (clk),
      .i_sclr (sclr),
      .i_ax   (ax),
      .i_ay   (ay),
      .i_ctl  (w_ctl_in),
      .o_prod (w_prod),
      .o_ctl  (w_ctl)
   );

   // Accumulate adder and wrap detection; the extra sum bit is the unsigned carry.
   always_comb begin
      // Channel is re-checked at full width so a corrupted control word cannot address past the array.
      w_take = w_ctl.valid && ({1'b0, w_ctl.chan} < CH_LIMIT_W);
      w_sel  = w_ctl.chan[CH_W-1:0];
      w_old  = r_acc[w_sel];
      w_sum  = {1'b0, w_old} + {1'b0, w_prod};
      w_new  = w_sum[RW-1:0];
      w_ov   = 1'b0;
      if (w_ctl.acc_clear) begin
         w_new = w_prod;
         w_ov  = 1'b0;
      end else if (SIGNED != 0) begin
         w_ov = (w_prod[RW-1] == w_old[RW-1]) && (w_sum[RW-1] != w_prod[RW-1]);
      end else begin
         w_ov = w_sum[RW];
      end
   end

   // Accumulator array and output registers; bubbles only drop valid_out, other outputs hold.
   always_ff @(posedge clk) begin
      if (sclr) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i] <= '0;
         end
         r_valid  <= 1'b0;
         r_chan   <= '0;
         r_result <= '0;
         r_ov     <= 1'b0;
      end else if (w_take) begin
         r_acc[w_sel] <= w_new;
         r_valid      <= 1'b1;
         r_chan       <= w_sel;
         r_result     <= w_new;
         r_ov         <= w_ov;
      end else begin
         r_valid <= 1'b0;
      end
   end

   assign valid_out = r_valid;
   assign chan_out  = r_chan;
   assign result    = r_result;
   assign overflow  = r_ov;

endmodule
